ft601_tx_mux: RTL and testbench
===============================

FT601_TX_MUX -- requirements
Module: ft601_tx_mux

Interface
REQ-001 Parameter NCH, default 2: number of producer channels, legal range 1..4.
REQ-002 Parameter DEPTH, default 512: words per channel FIFO, power of 2, 16..4096.
REQ-003 Parameter BURST, default 256: maximum data words per FT601 burst, 1..DEPTH.
REQ-004 Parameter AFULL_LVL, default DEPTH-8: per-channel almost-full threshold.
REQ-005 clk  in  1  single clock for the whole block (FT601 bus clock).
REQ-006 reset_n  in  1  reset, asynchronous assert, active-low; all state is cleared while low.
REQ-007 ch_data  in  NCH*36  write word per channel; channel c occupies bits [36c+35:36c]; [35:32] are byte enables.
REQ-008 ch_wr_en  in  NCH  write strobe per channel.
REQ-009 ch_push  in  NCH  request flush of the channel's buffered words regardless of BURST.
REQ-010 ch_afull  out  NCH  FIFO count >= AFULL_LVL.
REQ-011 ch_writeable  out  NCH  !ch_afull && !push_req for the channel.
REQ-012 ch_overflow  out  NCH  sticky; a write was attempted while the FIFO was full.
REQ-013 ft_txe_n  in  1  FT601 transmit-empty flag, active-low.
REQ-014 ft_wr_n  out  1  FT601 write strobe, active-low, registered.
REQ-015 ft_data  out  36  FT601 data and byte enables, registered.
REQ-016 busy  out  1  FSM is not in IDLE.

Function
REQ-017 Each channel has a synchronous FIFO of DEPTH x 36 with a count of width clog2(DEPTH)+1; a write occurs when ch_wr_en[c] is high and count < DEPTH.
REQ-018 A write to a full FIFO is dropped and sets ch_overflow[c] until reset.
REQ-019 A simultaneous write and pop on one channel leaves its count unchanged.
REQ-020 push_req[c] is set on the cycle after ch_push[c] or ch_afull[c] is high; push_req[c] is cleared in GAP when the burst just finished was channel c and its count is 0, and is cleared in any cycle where it is set and count is 0 while c is not granted.
REQ-021 Channel c is eligible when count >= BURST, or when push_req[c] is set and count > 0.
REQ-022 The arbiter is round-robin: the search starts at the channel after the last granted channel; after reset the search starts at channel 0.
REQ-023 FSM states are IDLE, HDR, DATA and GAP.
REQ-024 IDLE -> HDR when any channel is eligible and ft_txe_n is low; the arbiter latches grant and L = min(count, BURST) on that transition.
REQ-025 A transfer is an active clk edge with ft_wr_n == 0 and ft_txe_n == 0.
REQ-026 In HDR, ft_data = {4'hF, 4'hA, 4'(grant), 8'h00, 16'(L)} with ft_wr_n low; the FSM moves HDR -> DATA on the header transfer.
REQ-027 In DATA, ft_data = the FIFO head of the granted channel with ft_wr_n low; each transfer pops one word.
REQ-028 DATA -> GAP on the L-th data transfer.
REQ-029 GAP lasts exactly one cycle with ft_wr_n high, then the FSM returns to IDLE.
REQ-030 While ft_txe_n is high in HDR or DATA, ft_wr_n stays low and ft_data holds its value; no pop occurs.
REQ-031 Words written during a burst are not included in the L already latched; they remain for a later burst.
REQ-032 The header word-count field carries L exactly, including L = BURST.
REQ-033 ch_afull and ch_writeable are registered from the count and push_req; latency from the causing write is one cycle.

Reset
REQ-034 While reset_n is low, the outputs are: ft_wr_n = 1, ft_data = 0, busy = 0, ch_afull = 0, ch_writeable = all ones, ch_overflow = 0.
REQ-035 While reset_n is low, all FIFOs are empty, all push_req bits are clear, the FSM is in IDLE and the round-robin pointer selects channel 0.
REQ-036 Reset asserted mid-burst forces ft_wr_n high asynchronously; buffered data is discarded.
REQ-037 After reset release, normal operation starts on the first clk edge at which reset_n is sampled high.

Verification
REQ-038 With BURST = 4, write 4 words 0x1..0x4 on ch0 and hold ft_txe_n low -> header 0xFA0000004 is transferred, then words 0x1..0x4, then one GAP cycle.
REQ-039 Write 3 words on ch1 and pulse ch_push[1] -> header with channel = 1 and L = 3 is transferred, then push_req[1] clears and ch_writeable[1] returns high.
REQ-040 With both channels eligible continuously -> burst grants alternate ch0, ch1, ch0.
REQ-041 Raise ft_txe_n for 5 cycles after the 2nd data word -> ft_data holds the 3rd word with ft_wr_n low, and no word is lost or duplicated.
REQ-042 Fill ch0 to DEPTH and write one more word -> ch_overflow[0] = 1, the count stays at DEPTH, ch_afull[0] = 1, and ch_writeable[0] = 0.
REQ-043 Assert reset_n low during DATA -> ft_wr_n = 1 in the same cycle; after release busy = 0 and all counts are 0.

Source files
------------

// File: rtl/ft601_tx_mux.sv
// Multi-channel FIFO buffer and burst mux onto an FT601 245-style write bus.
// Each burst is a header word {F,A,chan,00,len} followed by len data words.
module ft601_tx_mux #(
   parameter int NCH       = 2,
   parameter int DEPTH     = 512,
   parameter int BURST     = 256,
   parameter int AFULL_LVL = DEPTH - 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NCH*36-1:0] ch_data,
   input  logic [NCH-1:0]    ch_wr_en,
   input  logic [NCH-1:0]    ch_push,
   output logic [NCH-1:0]    ch_afull,
   output logic [NCH-1:0]    ch_writeable,
   output logic [NCH-1:0]    ch_overflow,
   input  logic              ft_txe_n,
   output logic              ft_wr_n,
   output logic [35:0]       ft_data,
   output logic              busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

   state_t                  state;
   logic [GW-1:0]           grant, rr_ptr, sel;
   logic [CW-1:0]           len, wcnt, csel, l_sel;
   logic                    any_elig;
   logic [NCH-1:0]          elig, pop, gap_clr, served, push_req;
   logic [NCH-1:0][CW-1:0]  cnt;
   logic [NCH-1:0][35:0]    head, nxt;
   logic [35:0]             head_g, nxt_g;

   assign busy = (state != IDLE);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [35:0]   mem [DEPTH];
      logic [AW-1:0] wr_ptr, rd_ptr;
      logic          wr, push_nxt;
      logic [CW-1:0] cnt_nxt;

      assign pop[c]     = (state == DATA) && !ft_txe_n && (grant == GW'(c));
      assign gap_clr[c] = (state == GAP) && (grant == GW'(c));
      assign served[c]  = (state != IDLE) && (grant == GW'(c));
      assign wr         = ch_wr_en[c] && (cnt[c] < CW'(DEPTH));
      assign cnt_nxt    = cnt[c] + CW'(wr) - CW'(pop[c]);
      assign head[c]    = mem[rd_ptr];
      assign nxt[c]     = mem[rd_ptr + AW'(1)];
      assign elig[c]    = (cnt[c] >= CW'(BURST)) || (push_req[c] && (cnt[c] != '0));

      // Set wins over clear so a push on an empty channel still lasts one cycle.
      always_comb begin
         push_nxt = push_req[c];
         if ((gap_clr[c] || (push_req[c] && !served[c])) && (cnt[c] == '0))
            push_nxt = 1'b0;
         if (ch_push[c] || ch_afull[c])
            push_nxt = 1'b1;
      end

      always_ff @(posedge clk)
         if (wr) mem[wr_ptr] <= ch_data[36*c +: 36];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cnt[c]          <= '0;
            push_req[c]     <= 1'b0;
            ch_afull[c]     <= 1'b0;
            ch_writeable[c] <= 1'b1;
            ch_overflow[c]  <= 1'b0;
         end else begin
            if (wr)     wr_ptr <= wr_ptr + AW'(1);
            if (pop[c]) rd_ptr <= rd_ptr + AW'(1);
            if (ch_wr_en[c] && !wr) ch_overflow[c] <= 1'b1;
            cnt[c]          <= cnt_nxt;
            push_req[c]     <= push_nxt;
            ch_afull[c]     <= (cnt_nxt >= CW'(AFULL_LVL));
            ch_writeable[c] <= !(cnt_nxt >= CW'(AFULL_LVL)) && !push_nxt;
         end
      end
   end

   // Round-robin: the lowest offset from rr_ptr wins, so scan offsets high to low.
   always_comb begin
      int idx;
      any_elig = 1'b0;
      sel      = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NCH) idx = idx - NCH;
         if (elig[idx]) begin
            any_elig = 1'b1;
            sel      = GW'(idx);
         end
      end
   end

   always_comb begin
      csel   = '0;
      head_g = '0;
      nxt_g  = '0;
      for (int c = 0; c < NCH; c++) begin
         if (sel == GW'(c))   csel = cnt[c];
         if (grant == GW'(c)) begin
            head_g = head[c];
            nxt_g  = nxt[c];
         end
      end
      l_sel = (csel > CW'(BURST)) ? CW'(BURST) : csel;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         grant   <= '0;
         rr_ptr  <= '0;
         len     <= '0;
         wcnt    <= '0;
         ft_wr_n <= 1'b1;
         ft_data <= '0;
      end else begin
         case (state)
            IDLE: if (any_elig && !ft_txe_n) begin
               state   <= HDR;
               grant   <= sel;
               len     <= l_sel;
               wcnt    <= '0;
               rr_ptr  <= (sel == GW'(NCH - 1)) ? '0 : sel + GW'(1);
               ft_wr_n <= 1'b0;
               ft_data <= {4'hF, 4'hA, 4'(sel), 8'h00, 16'(l_sel)};
            end
            HDR: if (!ft_txe_n) begin
               state   <= DATA;
               ft_data <= head_g;
            end
            // Word wcnt is on the bus; its pop happens at this edge, so the next head is nxt.
            DATA: if (!ft_txe_n) begin
               if (wcnt + CW'(1) == len) begin
                  state   <= GAP;
                  ft_wr_n <= 1'b1;
               end else begin
                  wcnt    <= wcnt + CW'(1);
                  ft_data <= nxt_g;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ft601_tx_mux.sv
// Directed bench for ft601_tx_mux: table of single-channel bursts plus
// round-robin, stall, overflow and mid-burst reset sequences.
module tb_ft601_tx_mux;
   localparam int NCH = 2, DEPTH = 16, BURST = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NCH*36-1:0] ch_data = '0;
   logic [NCH-1:0]    ch_wr_en = '0, ch_push = '0;
   logic [NCH-1:0]    ch_afull, ch_writeable, ch_overflow;
   logic              ft_txe_n = 1'b1;
   logic              ft_wr_n;
   logic [35:0]       ft_data;
   logic              busy;

   int errors = 0, checks = 0;
   logic [35:0] xq[$];
   logic [35:0] exp_q[$];

   typedef struct {
      int          ch;
      int          n;
      bit          push;
      logic [35:0] base;
      logic [35:0] h1;
      logic [35:0] h2;
   } vec_t;
   vec_t vecs[5];

   ft601_tx_mux #(.NCH(NCH), .DEPTH(DEPTH), .BURST(BURST)) dut (
      .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .ch_wr_en(ch_wr_en),
      .ch_push(ch_push), .ch_afull(ch_afull), .ch_writeable(ch_writeable),
      .ch_overflow(ch_overflow), .ft_txe_n(ft_txe_n), .ft_wr_n(ft_wr_n),
      .ft_data(ft_data), .busy(busy));

   always #5 clk = ~clk;

   always @(posedge clk)
      if (reset_n && !ft_wr_n && !ft_txe_n) xq.push_back(ft_data);

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      xq.delete();
   endtask

   task automatic wr_words(input int ch, input int n, input logic [35:0] base);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ch_wr_en[ch]        = 1'b1;
         ch_data[36*ch +: 36] = base + 36'(i);
      end
      @(negedge clk);
      ch_wr_en = '0;
   endtask

   task automatic wait_xfers(input int n, input bit need_idle, input string name);
      int k = 0;
      while ((xq.size() < n || (need_idle && busy)) && k < 400) begin
         @(negedge clk);
         k++;
      end
      if (k >= 400) begin
         errors++;
         checks++;
         $display("FAIL %s timeout: got %0d transfers expected %0d", name, xq.size(), n);
      end
   endtask

   task automatic check_stream(input string name);
      chk({name, " len"}, 36'(xq.size()), 36'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < xq.size(); i++)
         chk($sformatf("%s[%0d]", name, i), xq[i], exp_q[i]);
   endtask

   initial begin
      vecs[0] = '{0, 4, 1'b0, 36'h1,  36'hFA0000004, 36'h0};
      vecs[1] = '{1, 3, 1'b1, 36'h10, 36'hFA1000003, 36'h0};
      vecs[2] = '{0, 2, 1'b1, 36'h20, 36'hFA0000002, 36'h0};
      vecs[3] = '{1, 5, 1'b1, 36'h30, 36'hFA1000004, 36'hFA1000001};
      vecs[4] = '{0, 1, 1'b1, 36'h50, 36'hFA0000001, 36'h0};

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst ft_wr_n", 36'(ft_wr_n), 36'h1);
      chk("rst ft_data", ft_data, 36'h0);
      chk("rst busy", 36'(busy), 36'h0);
      chk("rst afull", 36'(ch_afull), 36'h0);
      chk("rst writeable", 36'(ch_writeable), 36'h3);
      chk("rst overflow", 36'(ch_overflow), 36'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single-channel bursts from the table
      for (int v = 0; v < 5; v++) begin
         xq.delete();
         exp_q.delete();
         ft_txe_n = 1'b1;
         wr_words(vecs[v].ch, vecs[v].n, vecs[v].base);
         if (vecs[v].push) begin
            ch_push[vecs[v].ch] = 1'b1;
            @(negedge clk);
            ch_push = '0;
            chk($sformatf("v%0d writeable low", v), 36'(ch_writeable[vecs[v].ch]), 36'h0);
         end
         ft_txe_n = 1'b0;
         exp_q.push_back(vecs[v].h1);
         for (int i = 0; i < vecs[v].n && i < BURST; i++) exp_q.push_back(vecs[v].base + 36'(i));
         if (vecs[v].h2 != 36'h0) begin
            exp_q.push_back(vecs[v].h2);
            for (int i = BURST; i < vecs[v].n; i++) exp_q.push_back(vecs[v].base + 36'(i));
         end
         wait_xfers(exp_q.size(), 1'b1, $sformatf("v%0d", v));
         repeat (2) @(negedge clk);
         check_stream($sformatf("v%0d", v));
         chk($sformatf("v%0d writeable", v), 36'(ch_writeable), 36'h3);
         chk($sformatf("v%0d busy", v), 36'(busy), 36'h0);
      end

      // Round-robin with both channels eligible
      ft_txe_n = 1'b1;
      do_reset();
      exp_q.delete();
      wr_words(0, 8, 36'h100);
      wr_words(1, 8, 36'h200);
      ft_txe_n = 1'b0;
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back((b % 2 == 0) ? 36'hFA0000004 : 36'hFA1000004);
         for (int i = 0; i < 4; i++)
            exp_q.push_back(((b % 2 == 0) ? 36'h100 : 36'h200) + 36'((b / 2) * 4 + i));
      end
      wait_xfers(exp_q.size(), 1'b1, "rr");
      repeat (2) @(negedge clk);
      check_stream("rr");
      chk("rr writeable", 36'(ch_writeable), 36'h3);

      // Stall for 5 cycles after the 2nd data word
      ft_txe_n = 1'b1;
      do_reset();
      wr_words(0, 4, 36'h41);
      ft_txe_n = 1'b0;
      wait_xfers(3, 1'b0, "stall pre");
      ft_txe_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall wr_n %0d", i), 36'(ft_wr_n), 36'h0);
         chk($sformatf("stall data %0d", i), ft_data, 36'h43);
      end
      ft_txe_n = 1'b0;
      exp_q = '{36'hFA0000004, 36'h41, 36'h42, 36'h43, 36'h44};
      wait_xfers(5, 1'b1, "stall");
      repeat (3) @(negedge clk);
      check_stream("stall");

      // Overflow: 17 writes into a 16-deep FIFO
      ft_txe_n = 1'b1;
      do_reset();
      wr_words(0, 17, 36'h300);
      chk("ovf overflow", 36'(ch_overflow), 36'h1);
      chk("ovf afull", 36'(ch_afull[0]), 36'h1);
      chk("ovf writeable", 36'(ch_writeable[0]), 36'h0);
      exp_q.delete();
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back(36'hFA0000004);
         for (int i = 0; i < 4; i++) exp_q.push_back(36'h300 + 36'(b * 4 + i));
      end
      ft_txe_n = 1'b0;
      wait_xfers(exp_q.size(), 1'b1, "ovf");
      repeat (4) @(negedge clk);
      check_stream("ovf");
      chk("ovf sticky", 36'(ch_overflow), 36'h1);
      chk("ovf writeable after", 36'(ch_writeable), 36'h3);

      // Reset asserted during DATA
      xq.delete();
      ft_txe_n = 1'b1;
      wr_words(1, 4, 36'h500);
      ft_txe_n = 1'b0;
      wait_xfers(2, 1'b0, "mrst pre");
      chk("mrst in data", 36'(ft_wr_n), 36'h0);
      reset_n = 1'b0;
      #1;
      chk("mrst wr_n", 36'(ft_wr_n), 36'h1);
      chk("mrst data", ft_data, 36'h0);
      chk("mrst overflow", 36'(ch_overflow), 36'h0);
      chk("mrst writeable", 36'(ch_writeable), 36'h3);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("mrst busy", 36'(busy), 36'h0);
      ch_push = 2'b11;
      @(negedge clk);
      ch_push = '0;
      repeat (20) @(negedge clk);
      chk("mrst no xfer", 36'(xq.size()), 36'h2);
      chk("mrst idle", 36'(busy), 36'h0);
      chk("mrst writeable after", 36'(ch_writeable), 36'h3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
